// File: rtl/coffee_pkg.sv
// coffee_pkg: shared states, display characters, segment encoding and drink/sensor tables
package coffee_pkg;

    typedef enum logic [2:0] {IDLE, SELECTED, CHECK, BREW, DONE, ERROR} state_t;

    typedef enum logic [4:0] {
        CH_0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7, CH_8, CH_9,
        CH_C, CH_E, CH_L, CH_P, CH_R, CH_S, CH_N, CH_D, CH_I, CH_DASH, CH_BLANK
    } char_t;

    typedef logic [3:0][4:0] code_t;

    localparam char_t DRINK_LETTER [8] = '{CH_E, CH_L, CH_C, CH_P, CH_S, CH_N, CH_D, CH_R};
    localparam logic [7:0] PRICE [8] = '{8'h01, 8'h02, 8'h05, 8'h10, 8'h12, 8'h15, 8'h20, 8'h25};
    localparam char_t SENSOR_LETTER [9] = '{CH_R, CH_P, CH_N, CH_3, CH_4, CH_5, CH_6, CH_7, CH_8};

    function automatic logic [6:0] seg7(input char_t c);
        case (c)
            CH_0:    return 7'h7E;
            CH_1:    return 7'h30;
            CH_2:    return 7'h6D;
            CH_3:    return 7'h79;
            CH_4:    return 7'h33;
            CH_5:    return 7'h5B;
            CH_6:    return 7'h5F;
            CH_7:    return 7'h70;
            CH_8:    return 7'h7F;
            CH_9:    return 7'h7B;
            CH_C:    return 7'h4E;
            CH_E:    return 7'h4F;
            CH_L:    return 7'h0E;
            CH_P:    return 7'h67;
            CH_R:    return 7'h05;
            CH_S:    return 7'h5B;
            CH_N:    return 7'h15;
            CH_D:    return 7'h3D;
            CH_I:    return 7'h30;
            CH_DASH: return 7'h01;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/coffee_seg_scan.sv
// coffee_seg_scan: multiplexes a 4-character code onto registered seg/an/h outputs
module coffee_seg_scan
    import coffee_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  code_t      code,
    input  logic       dp,
    output logic [6:0] seg,
    output logic       h,
    output logic [3:0] an
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div;
    logic [1:0] dig;
    logic wrap;

    assign wrap = div == DW'(SCAN_DIV - 1);

    always_ff @(posedge CLK)
        if (RST) begin
            div <= '0;
            dig <= '0;
            an  <= 4'b0001;
            seg <= seg7(CH_DASH);
            h   <= 1'b0;
        end else begin
            div <= wrap ? '0 : div + 1'b1;
            dig <= wrap ? dig + 1'b1 : dig;
            an  <= 4'b0001 << dig;
            seg <= seg7(char_t'(code[dig]));
            h   <= dp && dig == 2'd0;
        end

endmodule

// File: rtl/coffee_ctrl_display.sv
// coffee_ctrl_display: drink selection/check/brew controller driving a 4-digit scanned display
module coffee_ctrl_display
    import coffee_pkg::*;
#(
    parameter int N_DRINKS    = 4,
    parameter int N_SENSORS   = 3,
    parameter int SCAN_DIV    = 4,
    parameter int BREW_CYCLES = 8,
    parameter int ERR_HOLD    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_DRINKS-1:0]  S,
    input  logic [N_SENSORS-1:0] SENS,
    input  logic                 VL,
    input  logic                 M,
    output logic [6:0]           seg,
    output logic                 h,
    output logic [3:0]           an,
    output logic                 busy,
    output logic                 done
);
    localparam int TMAX = BREW_CYCLES > ERR_HOLD ? BREW_CYCLES : ERR_HOLD;
    localparam int TW = $clog2(TMAX + 1);

    state_t state, nxt;
    logic [2:0] sel_idx, sel_nxt, s_idx;
    logic [3:0] err_k, err_k_nxt, f_idx;
    logic err_pay, err_pay_nxt, s_one;
    logic [TW-1:0] tmr, tmr_nxt;
    code_t code;

    always_ff @(posedge CLK)
        if (RST) begin
            state   <= IDLE;
            sel_idx <= '0;
            err_k   <= '0;
            err_pay <= 1'b0;
            tmr     <= '0;
        end else begin
            state   <= nxt;
            sel_idx <= sel_nxt;
            err_k   <= err_k_nxt;
            err_pay <= err_pay_nxt;
            tmr     <= tmr_nxt;
        end

    always_comb begin
        s_one = S != '0 && (S & (S - N_DRINKS'(1))) == '0;
        s_idx = '0;
        for (int i = N_DRINKS - 1; i >= 0; i--) if (S[i]) s_idx = 3'(i);
        f_idx = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) if (!SENS[i]) f_idx = 4'(i);
        nxt         = state;
        sel_nxt     = sel_idx;
        err_k_nxt   = err_k;
        err_pay_nxt = err_pay;
        tmr_nxt     = '0;
        case (state)
            IDLE: if (s_one) begin
                nxt     = SELECTED;
                sel_nxt = s_idx;
            end
            SELECTED: if (M) nxt = CHECK;
                      else if (s_one) sel_nxt = s_idx;
            CHECK: if (!(&SENS)) begin
                nxt         = ERROR;
                err_k_nxt   = f_idx;
                err_pay_nxt = 1'b0;
            end else if (!VL) begin
                nxt         = ERROR;
                err_pay_nxt = 1'b1;
            end else nxt = BREW;
            BREW: if (tmr == TW'(BREW_CYCLES - 1)) nxt = DONE;
                  else tmr_nxt = tmr + 1'b1;
            DONE: nxt = IDLE;
            ERROR: if (tmr == TW'(ERR_HOLD - 1)) nxt = IDLE;
                   else tmr_nxt = tmr + 1'b1;
            default: nxt = IDLE;
        endcase
        code = state == IDLE  ? {4{CH_DASH}} :
               state == ERROR ? {CH_E, CH_R, err_pay ? CH_D : CH_S, err_pay ? CH_I : SENSOR_LETTER[err_k]} :
                                {CH_C, DRINK_LETTER[sel_idx], char_t'({1'b0, PRICE[sel_idx][7:4]}),
                                 char_t'({1'b0, PRICE[sel_idx][3:0]})};
    end

    assign busy = state == CHECK || state == BREW;
    assign done = state == DONE;

    coffee_seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .CLK (CLK),
        .RST (RST),
        .code(code),
        .dp  (state == BREW),
        .seg (seg),
        .h   (h),
        .an  (an)
    );

endmodule

// File: tb/tb_coffee_ctrl_display.sv
// tb_coffee_ctrl_display: cycle model with scoreboard queue for the registered display outputs
module tb_coffee_ctrl_display;
    localparam int ND = 4, NS = 3, SD = 4, BC = 8, EH = 16;
    localparam int M_IDLE = 0, M_SEL = 1, M_CHECK = 2, M_BREW = 3, M_DONE = 4, M_ERR = 5;

    logic CLK = 1'b0, RST = 1'b1, VL = 1'b0, M = 1'b0;
    logic [ND-1:0] S = '0;
    logic [NS-1:0] SENS = '1;
    logic [6:0] seg;
    logic h, busy, done;
    logic [3:0] an;

    typedef struct packed {logic [6:0] seg; logic [3:0] an; logic h;} exp_t;
    exp_t q[$];
    int n_chk = 0, n_err = 0, ndone = 0;
    int st = M_IDLE, sel = 0, tmr = 0, div = 0, dig = 0;
    string errc = "";
    string dl = "ELCP";
    string sl = "RPN345678";
    string pr [4] = '{"01", "02", "05", "10"};

    coffee_ctrl_display #(.N_DRINKS(ND), .N_SENSORS(NS), .SCAN_DIV(SD), .BREW_CYCLES(BC), .ERR_HOLD(EH)) dut (
        .CLK(CLK), .RST(RST), .S(S), .SENS(SENS), .VL(VL), .M(M),
        .seg(seg), .h(h), .an(an), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] segof(input byte c);
        case (c)
            "0": return 7'b1111110;
            "1": return 7'b0110000;
            "2": return 7'b1101101;
            "5": return 7'b1011011;
            "C": return 7'b1001110;
            "E": return 7'b1001111;
            "L": return 7'b0001110;
            "P": return 7'b1100111;
            "R": return 7'b0000101;
            "S": return 7'b1011011;
            "D": return 7'b0111101;
            "I": return 7'b0110000;
            "-": return 7'b0000001;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    function automatic int low(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic string disp();
        if (st == M_IDLE) return "----";
        if (st == M_ERR) return errc;
        return $sformatf("C%c%s", dl[sel], pr[sel]);
    endfunction

    task automatic step();
        if (RST) begin
            st = M_IDLE; sel = 0; tmr = 0; div = 0; dig = 0;
            return;
        end
        if (div == SD - 1) begin div = 0; dig = (dig + 1) % 4; end
        else div++;
        case (st)
            M_IDLE: if ($countones(S) == 1) begin sel = low(8'(S)); st = M_SEL; end
            M_SEL: if (M) st = M_CHECK;
                   else if ($countones(S) == 1) sel = low(8'(S));
            M_CHECK: begin
                tmr = 0;
                if (SENS != '1) begin st = M_ERR; errc = $sformatf("ERS%c", sl[low(8'(~SENS))]); end
                else if (!VL) begin st = M_ERR; errc = "ERDI"; end
                else st = M_BREW;
            end
            M_BREW: if (tmr == BC - 1) begin st = M_DONE; tmr = 0; end else tmr++;
            M_DONE: st = M_IDLE;
            M_ERR: if (tmr == EH - 1) begin st = M_IDLE; tmr = 0; end else tmr++;
            default: st = M_IDLE;
        endcase
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            string d;
            exp_t e;
            check("busy", 16'(busy), 16'(st == M_CHECK || st == M_BREW));
            check("done", 16'(done), 16'(st == M_DONE));
            if (done) ndone++;
            d = disp();
            if (RST) begin
                e.seg = 7'b0000001; e.an = 4'b0001; e.h = 1'b0;
            end else begin
                e.seg = segof(d[3 - dig]); e.an = 4'(1 << dig); e.h = st == M_BREW && dig == 0;
            end
            q.push_back(e);
            @(posedge CLK);
            #1;
            e = q.pop_front();
            check("seg", 16'(seg), 16'(e.seg));
            check("an", 16'(an), 16'(e.an));
            check("h", 16'(h), 16'(e.h));
            step();
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check("rst_an", 16'(an), 16'h1);
        check("rst_seg", 16'(seg), 16'h01);
        check("rst_h", 16'(h), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        RST = 1'b0;
        cyc(4 * SD + 1);

        S = 4'b0010; cyc(1);
        S = '0; SENS = 3'b111; VL = 1'b1; M = 1'b1; cyc(1);
        M = 1'b0; ndone = 0; cyc(1 + BC + 4);
        check("brew_done_count", 16'(ndone), 16'd1);

        S = 4'b0001; cyc(1);
        S = '0; SENS = 3'b101; VL = 1'b0; M = 1'b1; cyc(1);
        M = 1'b0; ndone = 0; cyc(1 + EH + SD * 4);
        check("errsens_done_count", 16'(ndone), 16'd0);

        S = 4'b0100; SENS = 3'b111; cyc(1);
        S = '0; M = 1'b1; cyc(1);
        M = 1'b0; cyc(1 + EH + 4);
        check("errpay_done_count", 16'(ndone), 16'd0);

        S = 4'b0011; cyc(3);
        check("multihot_idle", 16'(st), 16'(M_IDLE));
        S = 4'b1000; cyc(1);
        S = 4'b0001; cyc(1);
        S = '0; cyc(SD * 4 + 2);

        VL = 1'b1; M = 1'b1; cyc(1);
        M = 1'b0;
        for (int i = 0; i < 20 && !(st == M_BREW && tmr == 4); i++) cyc(1);
        check("reached_brew4", 16'(st == M_BREW && tmr == 4), 16'd1);
        ndone = 0;
        RST = 1'b1; cyc(1);
        RST = 1'b0; cyc(1);
        check("abort_busy", 16'(busy), 16'h0);
        cyc(BC + 4);
        check("abort_no_done", 16'(ndone), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
